// File: rtl/fa_pkg.sv
// Shared constants and result type for the ripple-carry adder.
package fa_pkg;

  localparam int FA_WIDTH = 8;

  typedef struct packed {
    logic                cout;
    logic [FA_WIDTH-1:0] sum;
  } fa_result_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; one stage of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_8bit.sv
// Registered ripple-carry adder: {cout, sum} <= a + b + cin, one-cycle latency.
module fa_8bit
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = cin;

  // Plain ripple: carry i+1 comes only from stage i, no lookahead.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_comb;
      cout <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_fa_8bit.sv
// Directed and random checks of the registered 8-bit ripple-carry adder.
module tb_fa_8bit;
  import fa_pkg::*;

  logic                clk;
  logic                rst;
  logic [FA_WIDTH-1:0] a;
  logic [FA_WIDTH-1:0] b;
  logic                cin;
  logic [FA_WIDTH-1:0] sum;
  logic                cout;

  int checks   = 0;
  int failures = 0;

  fa_8bit #(.WIDTH(FA_WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_res(input string tag, input fa_result_t got, input fa_result_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got cout=%0b sum=%0d, expected cout=%0b sum=%0d",
               tag, got.cout, got.sum, exp.cout, exp.sum);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic fa_result_t res(input logic c, input logic [FA_WIDTH-1:0] s);
    fa_result_t r;
    r.cout = c;
    r.sum  = s;
    return r;
  endfunction

  // Directed back-to-back vectors: a, b, cin, expected cout, expected sum.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       cout;
    logic [7:0] sum;
  } vec_t;

  vec_t vecs [5] = '{
    '{8'd255, 8'd0,   1'b1, 1'b1, 8'd0},
    '{8'd100, 8'd27,  1'b1, 1'b0, 8'd128},
    '{8'd0,   8'd0,   1'b0, 1'b0, 8'd0},
    '{8'd10,  8'd20,  1'b0, 1'b0, 8'd30},
    '{8'd200, 8'd100, 1'b1, 1'b1, 8'd45}
  };

  initial begin
    logic [8:0] model;

    rst = 1'b1;
    a   = 8'hFF;
    b   = 8'hFF;
    cin = 1'b1;

    step();
    check_res("reset_edge1", res(cout, sum), res(1'b0, 8'd0));
    step();
    check_res("reset_edge2", res(cout, sum), res(1'b0, 8'd0));

    rst = 1'b0;
    step();
    check_res("after_reset_max", res(cout, sum), res(1'b1, 8'd255));

    // Reset raised between edges must not disturb the outputs until the edge.
    #2 rst = 1'b1;
    #2;
    check_res("reset_between_edges", res(cout, sum), res(1'b1, 8'd255));
    step();
    check_res("reset_at_edge", res(cout, sum), res(1'b0, 8'd0));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      a   = vecs[i].a;
      b   = vecs[i].b;
      cin = vecs[i].cin;
      step();
      check_res($sformatf("directed_%0d", i), res(cout, sum), res(vecs[i].cout, vecs[i].sum));
    end

    // Output holds between edges with inputs changing.
    a   = 8'd1;
    b   = 8'd1;
    cin = 1'b0;
    #3;
    check_res("hold_between_edges", res(cout, sum), res(1'b1, 8'd45));

    a   = 8'd50;
    b   = 8'd50;
    cin = 1'b0;
    rst = 1'b1;
    step();
    check_res("midstream_reset", res(cout, sum), res(1'b0, 8'd0));
    rst = 1'b0;
    step();
    check_res("midstream_release", res(cout, sum), res(1'b0, 8'd100));

    for (int i = 0; i < 256; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      model = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      step();
      step();
      $display("vec %0d: a=%0d b=%0d cin=%0b sum=%0d cout=%0b", i, a, b, cin, sum, cout);
      check_res($sformatf("random_%0d", i), res(cout, sum), res(model[8], model[7:0]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fa_8bit.md
# fa_8bit

Registered 8-bit ripple-carry adder. Computes `a + b + cin` through a chain of eight one-bit full adders and captures the 8-bit sum and carry-out in output registers on the rising clock edge. It is a leaf arithmetic block for datapaths that need a simple, area-minimal adder with a one-cycle registered result.

## Interface
- `WIDTH`, default 8: operand and sum width. Only 8 is required to be verified.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  reset, synchronous and active-high.
- `a`  input  WIDTH  operand A, unsigned.
- `b`  input  WIDTH  operand B, unsigned.
- `cin`  input  1  carry into bit 0.
- `sum`  output  WIDTH  registered low WIDTH bits of `a + b + cin`.
- `cout`  output  1  registered carry out of bit WIDTH-1.

## Operation
- Stage i (0..WIDTH-1) is a full adder:
  - `s[i] = a[i] ^ b[i] ^ c[i]`
  - `c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]`
  - `c[0] = cin`
- The carry ripples from bit 0 to bit WIDTH-1. No lookahead or carry-select logic is used.
- Arithmetic is unsigned modulo 2^WIDTH. `{cout, sum}` equals the (WIDTH+1)-bit value `a + b + cin`. The range is 0..511 for WIDTH=8.
- No overflow flag and no signed interpretation; `cout` is the only carry indication.
- Inputs are not registered. The ripple chain is purely combinational from the input ports to the output register D-inputs.

## Timing
- On the rising edge of `clk`:
  - if `rst`=1: `sum` <= 0 and `cout` <= 0;
  - otherwise `{cout, sum}` <= `a + b + cin`.
- Reset value of every output: `sum`=0, `cout`=0. Reset takes effect only on a clock edge; asserting `rst` between edges does not change the outputs.
- Latency is 1 cycle. Inputs stable before edge N appear on the outputs just after edge N and hold until the next edge.
- Throughput is one new operand set per cycle. There is no handshake and no valid signal; every cycle is a computation.
- Reset mid-operation: the result of the cycle in which `rst` is high is discarded, and the outputs read 0. The first cycle after deassertion produces the sum of the inputs present at that edge.
- Critical path: `cin` or `a[0]`/`b[0]` through 8 carry stages to `cout`. It must close within one clock period.

## Structure
- Shared package `fa_pkg`: constant `FA_WIDTH = 8`, plus the `{cout, sum}` result typedef (`fa_result_t`, WIDTH+1 bits).
- One sub-module, `full_adder`: ports `a`, `b`, `cin`, `s`, `cout`, all 1 bit, purely combinational.
- The top level instantiates WIDTH `full_adder` instances in a generate loop and chains the carries. It also holds the output register with synchronous reset.
- No behavioural `+` operator in the datapath. Bench models may use `+`.

## Test plan
- Reset: assert `rst` for 2 cycles with `a`=8'hFF, `b`=8'hFF, `cin`=1 -> `sum`=0, `cout`=0. Deassert `rst` -> next edge gives `sum`=255, `cout`=1.
- Full carry ripple: `a`=255, `b`=0, `cin`=1 -> `sum`=0, `cout`=1 after one edge.
- No carry: `a`=100, `b`=27, `cin`=1 -> `sum`=128, `cout`=0. Then `a`=0, `b`=0, `cin`=0 -> `sum`=0, `cout`=0.
- Back-to-back vectors on consecutive cycles: (10,20,0) then (200,100,1) -> `sum`=30, `cout`=0 then `sum`=45, `cout`=1, each one cycle after its inputs.
- Reset mid-stream: apply (50,50,0) with `rst` high for one edge -> `sum`=0, `cout`=0. Next edge with `rst` low -> `sum`=100, `cout`=0.
- Random sweep, clock period 10 time units:
  - 256 vectors, `a`,`b` uniform over 0..255 and `cin` over 0..1;
  - each vector held 20 time units (2 edges);
  - after each vector, check `{cout, sum}` == `a + b + cin` and print a, b, cin, sum, cout.
